// File: rtl/mopshub_test_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mopshub_test_sequencer: RX -> endwait -> gap -> TX test-run sequencer
// with per-phase watchdog, saturating frame counters and trim flag. Rev 1.0
// ----------------------------------------------------------------------------
module mopshub_test_sequencer #(
  parameter int GAP_CYCLES     = 120,
  parameter int ENDWAIT_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        trim_req,
  input  logic        end_power_init,
  input  logic        enable_tx,
  input  logic        test_rx_end,
  input  logic        test_tx_end,
  input  logic        irq_elink_rec,
  input  logic        irq_elink_tra,
  input  logic        clear_err,
  output logic        osc_auto_trim,
  output logic        test_rx,
  output logic        test_tx,
  output logic        endwait_all,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [2:0]  state_dbg,
  output logic [15:0] rec_cnt,
  output logic [15:0] tra_cnt
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RX_RUN  = 3'd1;
  localparam logic [2:0] c_ENDWAIT = 3'd2;
  localparam logic [2:0] c_GAP     = 3'd3;
  localparam logic [2:0] c_TX_RUN  = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;
  localparam logic [2:0] c_ERROR   = 3'd6;

  localparam logic [19:0] c_TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] c_GAP_LAST     = 20'(GAP_CYCLES - 1);
  localparam logic [19:0] c_ENDWAIT_LAST = 20'(ENDWAIT_CYCLES - 1);
  localparam logic [15:0] c_CNT_MAX      = 16'hFFFF;

  logic [2:0]  state_q, state_d;
  // Shared phase counter: watchdog in RX/TX, duration timer in ENDWAIT/GAP
  logic [19:0] cnt_q, cnt_d;
  logic [15:0] rec_q, rec_d;
  logic [15:0] tra_q, tra_d;
  logic        trim_q, trim_d;
  logic        test_rx_q, test_tx_q, endwait_q, busy_q, done_q, err_q;
  logic        w_run_start;

  assign w_run_start = (state_q == c_IDLE) && start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_RX_RUN;
          cnt_d   = '0;
        end
      end
      c_RX_RUN: begin
        if (test_rx_end) begin
          state_d = c_ENDWAIT;
          cnt_d   = '0;
        end else if (cnt_q >= c_TIMEOUT_LAST) begin
          state_d = c_ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      c_ENDWAIT: begin
        if (cnt_q >= c_ENDWAIT_LAST) begin
          state_d = c_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      c_GAP: begin
        if (cnt_q >= c_GAP_LAST) begin
          state_d = enable_tx ? c_TX_RUN : c_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      c_TX_RUN: begin
        if (test_tx_end) begin
          state_d = c_DONE;
          cnt_d   = '0;
        end else if (cnt_q >= c_TIMEOUT_LAST) begin
          state_d = c_ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
        cnt_d   = '0;
      end
      c_ERROR: begin
        if (clear_err) begin
          state_d = c_IDLE;
        end
        cnt_d = '0;
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rec_d = rec_q;
    tra_d = tra_q;
    if (w_run_start) begin
      rec_d = '0;
      tra_d = '0;
    end else if (busy_q) begin
      if (irq_elink_rec && (rec_q != c_CNT_MAX)) rec_d = rec_q + 16'd1;
      if (irq_elink_tra && (tra_q != c_CNT_MAX)) tra_d = tra_q + 16'd1;
    end
  end

  // Clear dominates set when both arrive together
  always_comb begin
    trim_d = trim_q;
    if (end_power_init) trim_d = 1'b0;
    else if (trim_req)  trim_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      rec_q     <= '0;
      tra_q     <= '0;
      trim_q    <= 1'b0;
      test_rx_q <= 1'b0;
      test_tx_q <= 1'b0;
      endwait_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rec_q     <= rec_d;
      tra_q     <= tra_d;
      trim_q    <= trim_d;
      test_rx_q <= (state_d == c_RX_RUN);
      test_tx_q <= (state_d == c_TX_RUN);
      endwait_q <= (state_d == c_ENDWAIT);
      busy_q    <= (state_d != c_IDLE) && (state_d != c_ERROR);
      done_q    <= (state_d == c_DONE);
      err_q     <= (state_d == c_ERROR);
    end
  end

  assign osc_auto_trim = trim_q;
  assign test_rx       = test_rx_q;
  assign test_tx       = test_tx_q;
  assign endwait_all   = endwait_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = err_q;
  assign state_dbg     = state_q;
  assign rec_cnt       = rec_q;
  assign tra_cnt       = tra_q;

endmodule
`default_nettype wire

// File: tb/tb_mopshub_test_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mopshub_test_sequencer: directed bench with a state-sequence scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mopshub_test_sequencer;

  logic clk = 1'b0;
  logic rst, start, trim_req, end_power_init, enable_tx;
  logic test_rx_end, test_tx_end, irq_elink_rec, irq_elink_tra, clear_err;

  logic        osc_auto_trim, test_rx, test_tx, endwait_all, busy, done, timeout_err;
  logic [2:0]  state_dbg;
  logic [15:0] rec_cnt, tra_cnt;

  logic        osc_auto_trim_b, test_rx_b, test_tx_b, endwait_all_b, busy_b, done_b, timeout_err_b;
  logic [2:0]  state_dbg_b;
  logic [15:0] rec_cnt_b, tra_cnt_b;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int exp_q[$];
  logic [2:0] mon_prev = 3'd0;

  always #12 clk = ~clk;

  mopshub_test_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .trim_req(trim_req),
    .end_power_init(end_power_init), .enable_tx(enable_tx),
    .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
    .irq_elink_rec(irq_elink_rec), .irq_elink_tra(irq_elink_tra),
    .clear_err(clear_err), .osc_auto_trim(osc_auto_trim), .test_rx(test_rx),
    .test_tx(test_tx), .endwait_all(endwait_all), .busy(busy), .done(done),
    .timeout_err(timeout_err), .state_dbg(state_dbg), .rec_cnt(rec_cnt),
    .tra_cnt(tra_cnt)
  );

  mopshub_test_sequencer #(.TIMEOUT_CYCLES(100)) u_wd (
    .clk(clk), .rst(rst), .start(start), .trim_req(trim_req),
    .end_power_init(end_power_init), .enable_tx(enable_tx),
    .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
    .irq_elink_rec(irq_elink_rec), .irq_elink_tra(irq_elink_tra),
    .clear_err(clear_err), .osc_auto_trim(osc_auto_trim_b), .test_rx(test_rx_b),
    .test_tx(test_tx_b), .endwait_all(endwait_all_b), .busy(busy_b), .done(done_b),
    .timeout_err(timeout_err_b), .state_dbg(state_dbg_b), .rec_cnt(rec_cnt_b),
    .tra_cnt(tra_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every state change of u_dut is matched against the next queued expectation
  always @(negedge clk) begin
    if (state_dbg != mon_prev) begin
      chk("state_seq_pending", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) chk("state_seq", {29'd0, state_dbg}, exp_q.pop_front());
      mon_prev = state_dbg;
    end
  end

  initial begin
    int k, ew, n, tx_seen, dones, rx_cyc;
    rst = 1'b1; start = 1'b0; trim_req = 1'b0; end_power_init = 1'b0; enable_tx = 1'b0;
    test_rx_end = 1'b0; test_tx_end = 1'b0; irq_elink_rec = 1'b0; irq_elink_tra = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    chk("rst_test_rx", {31'd0, test_rx}, 32'd0);
    chk("rst_test_tx", {31'd0, test_tx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_endwait", {31'd0, endwait_all}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_osc", {31'd0, osc_auto_trim}, 32'd0);
    chk("rst_rec", {16'd0, rec_cnt}, 32'd0);
    chk("rst_tra", {16'd0, tra_cnt}, 32'd0);
    rst = 1'b0;

    // Nominal run with TX enabled
    enable_tx = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("nom_rx_state", {29'd0, state_dbg}, 32'd1);
    chk("nom_test_rx", {31'd0, test_rx}, 32'd1);
    chk("nom_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 49; i++) begin
      irq_elink_rec = (i <= 10);
      start         = (i == 20);
      test_tx_end   = (i == 20);
      @(negedge clk);
    end
    irq_elink_rec = 1'b0; start = 1'b0; test_tx_end = 1'b0;
    test_rx_end = 1'b1; @(negedge clk); test_rx_end = 1'b0;
    chk("nom_endwait_state", {29'd0, state_dbg}, 32'd2);
    chk("nom_test_rx_fall", {31'd0, test_rx}, 32'd0);
    chk("nom_rec_cnt", {16'd0, rec_cnt}, 32'd10);
    k = 0; ew = 0;
    while (test_tx !== 1'b1 && k < 1000) begin
      if (endwait_all) ew++;
      @(negedge clk);
      k++;
    end
    chk("nom_rx_to_tx_cycles", k, 32'd121);
    chk("nom_endwait_width", ew, 32'd1);
    for (int i = 1; i <= 79; i++) begin
      irq_elink_tra = (i <= 5);
      @(negedge clk);
    end
    irq_elink_tra = 1'b0;
    test_tx_end = 1'b1; @(negedge clk); test_tx_end = 1'b0;
    chk("nom_done_state", {29'd0, state_dbg}, 32'd5);
    chk("nom_done_pulse", {31'd0, done}, 32'd1);
    chk("nom_test_tx_fall", {31'd0, test_tx}, 32'd0);
    chk("nom_tra_cnt", {16'd0, tra_cnt}, 32'd5);
    @(negedge clk);
    chk("nom_done_drop", {31'd0, done}, 32'd0);
    chk("nom_idle_busy", {31'd0, busy}, 32'd0);
    chk("nom_rec_hold", {16'd0, rec_cnt}, 32'd10);

    // TX phase skipped
    enable_tx = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(5); exp_q.push_back(0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("skip_rec_clear", {16'd0, rec_cnt}, 32'd0);
    chk("skip_tra_clear", {16'd0, tra_cnt}, 32'd0);
    repeat (4) @(negedge clk);
    test_rx_end = 1'b1; @(negedge clk); test_rx_end = 1'b0;
    n = 0; tx_seen = 0; dones = 0;
    while (state_dbg !== 3'd0 && n < 500) begin
      if (test_tx) tx_seen++;
      if (done) dones++;
      @(negedge clk);
      n++;
    end
    chk("skip_idle", {29'd0, state_dbg}, 32'd0);
    chk("skip_no_tx", tx_seen, 32'd0);
    chk("skip_done_once", dones, 32'd1);

    // Watchdog expiry on the short-timeout instance
    exp_q.push_back(1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0; rx_cyc = 0;
    while (state_dbg_b !== 3'd6 && n < 300) begin
      if (test_rx_b) rx_cyc++;
      irq_elink_rec = (n < 3);
      @(negedge clk);
      n++;
    end
    irq_elink_rec = 1'b0;
    chk("to_rx_cycles", rx_cyc, 32'd100);
    chk("to_state", {29'd0, state_dbg_b}, 32'd6);
    chk("to_err", {31'd0, timeout_err_b}, 32'd1);
    chk("to_test_rx", {31'd0, test_rx_b}, 32'd0);
    chk("to_test_tx", {31'd0, test_tx_b}, 32'd0);
    chk("to_busy", {31'd0, busy_b}, 32'd0);
    irq_elink_rec = 1'b1; repeat (3) @(negedge clk); irq_elink_rec = 1'b0;
    chk("to_rec_hold", {16'd0, rec_cnt_b}, 32'd3);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("to_clear_state", {29'd0, state_dbg_b}, 32'd0);
    chk("to_clear_err", {31'd0, timeout_err_b}, 32'd0);

    // End pulse coinciding with expiry wins
    start = 1'b1; @(negedge clk); start = 1'b0;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(0);
    repeat (99) @(negedge clk);
    test_rx_end = 1'b1; @(negedge clk); test_rx_end = 1'b0;
    chk("tie_state_b", {29'd0, state_dbg_b}, 32'd2);
    chk("tie_err_b", {31'd0, timeout_err_b}, 32'd0);
    chk("tie_state", {29'd0, state_dbg}, 32'd2);
    n = 0;
    while ((state_dbg !== 3'd0 || state_dbg_b !== 3'd0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tie_idle", {29'd0, state_dbg}, 32'd0);
    chk("tie_idle_b", {29'd0, state_dbg_b}, 32'd0);

    // Counter saturation and clear on next start
    exp_q.push_back(1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    irq_elink_rec = 1'b1; repeat (70000) @(negedge clk); irq_elink_rec = 1'b0;
    chk("sat_rec", {16'd0, rec_cnt}, 32'h0000FFFF);
    chk("sat_state", {29'd0, state_dbg}, 32'd1);
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(0);
    test_rx_end = 1'b1; @(negedge clk); test_rx_end = 1'b0;
    n = 0;
    while (state_dbg !== 3'd0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("sat_idle", {29'd0, state_dbg}, 32'd0);
    chk("sat_hold", {16'd0, rec_cnt}, 32'h0000FFFF);
    exp_q.push_back(1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("sat_clear", {16'd0, rec_cnt}, 32'd0);

    // Trim flag, then reset during TX
    trim_req = 1'b1; @(negedge clk); trim_req = 1'b0;
    chk("trim_set", {31'd0, osc_auto_trim}, 32'd1);
    trim_req = 1'b1; end_power_init = 1'b1; @(negedge clk);
    trim_req = 1'b0; end_power_init = 1'b0;
    chk("trim_clear_wins", {31'd0, osc_auto_trim}, 32'd0);
    trim_req = 1'b1; @(negedge clk); trim_req = 1'b0;
    chk("trim_reset_b", {31'd0, osc_auto_trim_b}, 32'd1);
    enable_tx = 1'b1;
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    test_rx_end = 1'b1; @(negedge clk); test_rx_end = 1'b0;
    n = 0;
    while (test_tx !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rtx_in_tx", {31'd0, test_tx}, 32'd1);
    irq_elink_tra = 1'b1; repeat (3) @(negedge clk); irq_elink_tra = 1'b0;
    chk("rtx_tra", {16'd0, tra_cnt}, 32'd3);
    exp_q.push_back(0);
    rst = 1'b1; @(negedge clk);
    chk("rtx_state", {29'd0, state_dbg}, 32'd0);
    chk("rtx_test_tx", {31'd0, test_tx}, 32'd0);
    chk("rtx_busy", {31'd0, busy}, 32'd0);
    chk("rtx_done", {31'd0, done}, 32'd0);
    chk("rtx_tra_clr", {16'd0, tra_cnt}, 32'd0);
    chk("rtx_osc", {31'd0, osc_auto_trim}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("seq_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mopshub_test_sequencer.md
MOPSHUB_TEST_SEQUENCER -- requirements
Module: mopshub_test_sequencer

Interface
REQ-001 The block SHALL expose parameter GAP_CYCLES, default 120, as the number of idle cycles between the RX and TX phases (3 us at 40 MHz).
REQ-002 The block SHALL expose parameter ENDWAIT_CYCLES, default 1, as the width in cycles of the endwait_all pulse.
REQ-003 The block SHALL expose parameter TIMEOUT_CYCLES, default 400000, as the per-phase watchdog limit in cycles; it SHALL be held in a 20-bit counter.
REQ-004 The block SHALL provide port clk, input, 1 bit: single clock (40 MHz domain); all logic is on its rising edge.
REQ-005 The block SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL provide port start, input, 1 bit: sign-on indication from the hub; it starts a test run.
REQ-007 The block SHALL provide port trim_req, input, 1 bit: a pulse that requests oscillator auto-trim.
REQ-008 The block SHALL provide port end_power_init, input, 1 bit: the hub has finished power-up and trim.
REQ-009 The block SHALL provide port enable_tx, input, 1 bit: when 1, the TX phase runs after the RX phase.
REQ-010 The block SHALL provide ports test_rx_end and test_tx_end, input, 1 bit each: phase-complete pulses from the data generator.
REQ-011 The block SHALL provide ports irq_elink_rec and irq_elink_tra, input, 1 bit each: per-frame uplink and downlink strobes.
REQ-012 The block SHALL provide port clear_err, input, 1 bit: clears the error state.
REQ-013 The block SHALL provide ports osc_auto_trim, test_rx, test_tx, endwait_all, busy, done and timeout_err, output, 1 bit each.
REQ-014 The block SHALL provide port state_dbg, output, 3 bits: the current state code.
REQ-015 The block SHALL provide ports rec_cnt and tra_cnt, output, 16 bits each: frame counters.

Function
REQ-016 The state codes SHALL be IDLE=0, RX_RUN=1, ENDWAIT=2, GAP=3, TX_RUN=4, DONE=5, ERROR=6; state_dbg SHALL equal the current state.
REQ-017 In IDLE, start=1 SHALL cause a transition to RX_RUN on the next edge; that same edge SHALL clear rec_cnt, tra_cnt and the watchdog.
REQ-018 test_rx SHALL be 1 exactly while the state is RX_RUN, driven from a register so that it has zero combinational path from inputs.
REQ-019 In RX_RUN, test_rx_end=1 SHALL cause a transition to ENDWAIT.
REQ-020 endwait_all SHALL be 1 for exactly ENDWAIT_CYCLES cycles in ENDWAIT, after which the state SHALL be GAP.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles.
REQ-022 On leaving GAP, the next state SHALL be TX_RUN if enable_tx=1 (sampled on the last GAP cycle), else DONE.
REQ-023 test_tx SHALL be 1 exactly while the state is TX_RUN; test_tx_end=1 in TX_RUN SHALL cause a transition to DONE.
REQ-024 DONE SHALL last one cycle with done=1 (a single-cycle pulse), then the state SHALL return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-026 The watchdog SHALL count cycles in RX_RUN and TX_RUN and SHALL reset on each phase entry; reaching TIMEOUT_CYCLES-1 without an end pulse SHALL cause a transition to ERROR.
REQ-027 If an end pulse and watchdog expiry coincide, the end pulse SHALL win.
REQ-028 In ERROR, timeout_err SHALL be 1 and test_rx and test_tx SHALL be 0; clear_err=1 SHALL return the state to IDLE and clear timeout_err on the same edge.
REQ-029 start SHALL be ignored outside IDLE; test_rx_end and test_tx_end SHALL be ignored outside their own phase.
REQ-030 rec_cnt SHALL increment by one per cycle with irq_elink_rec=1 while busy=1, and tra_cnt likewise with irq_elink_tra; both SHALL saturate at 16'hFFFF and hold their values after DONE or ERROR until the next start.
REQ-031 osc_auto_trim SHALL be set by trim_req=1 and cleared by end_power_init=1; if both are 1 in the same cycle, clear SHALL win.
REQ-032 osc_auto_trim SHALL be independent of the test state machine.

Reset
REQ-033 While rst=1 on a clock edge, the state SHALL go to IDLE and all outputs SHALL go to 0 (state_dbg=0, rec_cnt=0, tra_cnt=0, osc_auto_trim=0), and all internal counters SHALL clear.
REQ-034 Reset asserted mid-phase SHALL drop test_rx and test_tx on that edge, with no done pulse.

Verification
REQ-035 The bench SHALL cover the nominal run: start pulse, test_rx_end 50 cycles later, test_tx_end 80 cycles into TX with enable_tx=1 -> endwait_all high for 1 cycle, test_tx rising exactly 121 cycles after test_rx falls, done pulsing once, state_dbg sequence 0,1,2,3,4,5,0.
REQ-036 The bench SHALL cover the skipped TX phase: enable_tx=0 -> GAP goes to DONE and test_tx never goes to 1.
REQ-037 The bench SHALL cover the timeout case: TIMEOUT_CYCLES=100 and no test_rx_end -> ERROR on cycle 100 of RX_RUN with timeout_err=1 and test_rx=0; clear_err -> IDLE.
REQ-038 The bench SHALL cover counter behaviour: 70000 cycles of irq_elink_rec=1 during RX_RUN -> rec_cnt=16'hFFFF; the next start -> rec_cnt=0.
REQ-039 The bench SHALL cover trim and reset: trim_req and end_power_init in the same cycle -> osc_auto_trim=0; rst pulsed during TX_RUN -> all outputs 0 on the next edge.
